sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Three-client arbiter that shares one two-port SRAM wrapper between two read clients (load pipes `rd0`, `rd1`) and one write client (`wr`). It maps requests onto the wrapper's read/write port 0 and read-only port 1, blocks same-address read/write collisions, and bounds read starvation. It also tracks in-flight reads through the wrapper's fixed 2-cycle read latency and returns each result to the client that issued it.

## Interface
Parameters:
- `SIZE_IN_WORDS`, 1024, SRAM depth in words; must match the wrapper.
- `WORD_SIZE`, 32, data width in bits.
- `ADDR_LEN`, `$clog2(SIZE_IN_WORDS)`, address width.
- `STALL_MAX`, 3, number of consecutive collision-blocked cycles before the write is held off; must be ≥ 1.

Ports:
- `clk` in 1: clock. Single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `rd0_valid` in 1: read request from client 0.
- `rd0_ready` out 1: grant to client 0; combinational from this cycle's requests.
- `rd0_addr` in ADDR_LEN: read address for client 0.
- `rd0_rvalid` out 1: read data valid for client 0; one-cycle pulse.
- `rd0_rdata` out WORD_SIZE: read data for client 0.
- `rd1_*`: same set of signals as `rd0_*`, for client 1.
- `wr_valid` in 1: write request.
- `wr_ready` out 1: write grant.
- `wr_addr` in ADDR_LEN: write address.
- `wr_data` in WORD_SIZE: write data.
- `wr_mask` in WORD_SIZE/8: byte write enables.
- `nce0`, `nwe0`, `addr0`, `wdata0`, `wmask0` out: to SRAM port 0. All combinational from this cycle's grant.
- `rdata0` in WORD_SIZE: from SRAM port 0.
- `nce1`, `addr1` out: to SRAM port 1. Combinational.
- `rdata1` in WORD_SIZE: from SRAM port 1.

## Operation
- A transfer occurs on `X_valid && X_ready`. `ready` may depend on `valid`. Clients must hold `valid` and the payload stable until granted.
- Port 0 priority: a granted write takes precedence. Otherwise port 0 serves one read.
- Port 1 serves reads only.
- Collision rule: a read whose address equals `wr_addr` is not granted in a cycle where the write is granted. Once the write is done, the read returns the new data.
- Read slot assignment:
  - Two read slots free and both reads eligible: `rd0` goes to port 1, `rd1` goes to port 0.
  - One read slot free (write granted): the eligible read selected by the round-robin pointer `rr` goes to port 1.
  - Exactly one read eligible: it goes to port 1.
- `rr`:
  - Reset value 0, meaning `rd0` is favoured.
  - Flips only when both reads are eligible, only one slot exists, and the favoured client is granted. `rr` then points at the loser.
- Starvation counter `stall_cnt`, width `$clog2(STALL_MAX+1)`, reset value 0:
  - Increments in any cycle where some read is valid, no read is granted, and the collision rule blocked at least one read.
  - Clears on any read grant.
  - Saturates at `STALL_MAX`.
  - While `stall_cnt == STALL_MAX`: `wr_ready = 0`, so reads take both ports. The counter then clears on the resulting read grant.
- SRAM port signals:
  - Idle port: `nce = 1`; `addr`/`wdata` are don't-care.
  - Port 0 write: `nwe0 = 0`, `wmask0 = wr_mask`.
  - Port 0 read: `nwe0 = 1`.
- Return pipeline: a two-stage shift register of `{valid, client_id, port}` per port.
  - At stage 2, drive `rdX_rvalid` for the tagged client.
  - Drive `rdX_rdata` from `rdata0` or `rdata1` according to the tagged port.
  - Both clients may receive data in the same cycle.
- Reset:
  - Outputs held during `rst`: all `ready = 0`, `nce0 = nce1 = 1`, `nwe0 = 1`, all `rvalid = 0`.
  - State cleared: return pipeline, `rr`, `stall_cnt`.
  - Reads in flight when `rst` is asserted are discarded; no `rvalid` appears for them after `rst` deasserts.

## Timing
- Grant in cycle T. The SRAM samples the request at the end of T. `rvalid` is high in cycle T+2 for exactly one cycle, with `rdata` valid in the same cycle.
- Throughput: up to 2 reads per cycle, or 1 write plus 1 read per cycle. There are no bubbles between back-to-back grants.
- Per-client responses return in grant order. Latency is a fixed 2 cycles, regardless of port.
- A write granted in cycle T is visible to a read granted in cycle T+1 or later.
- `rdX_rdata` when `rvalid = 0`: don't-care.

## Test plan
- Reset: assert `rst` with `rd0_valid` held high.
  - Required: `rd0_ready = 0` and `nce0 = nce1 = 1` throughout reset.
  - Required: the first grant occurs in the first cycle after `rst` deasserts, and `rd0_rvalid` rises 2 cycles later.
- Dual read: `rd0` addr 5 and `rd1` addr 600 in the same cycle, with SRAM model word[5] = `0xAAAA0005` and word[600] = `0xBBBB0258`.
  - Required: both granted in cycle T.
  - Required: `rd0_rdata = 0xAAAA0005` and `rd1_rdata = 0xBBBB0258` in cycle T+2.
- Contention with write: write addr 7 plus both reads valid (addr 1, 2) for 4 cycles.
  - Required: the write is granted every cycle.
  - Required: read grants alternate `rd0`, `rd1`, `rd0`, `rd1`.
- Collision: in cycle T, write addr 9 with data `0x12345678` and `rd0` addr 9.
  - Required: `rd0` is stalled in cycle T and granted in cycle T+1.
  - Required: `rd0_rdata = 0x12345678` in cycle T+3.
- Starvation: `wr_valid` held high at addr 9 every cycle, and `rd0` requests addr 9, with `STALL_MAX = 3`.
  - Required: `rd0` is blocked for 3 cycles, then `wr_ready = 0` for 1 cycle and `rd0` is granted in that cycle.
  - Required: the write resumes the following cycle.
- Mid-flight reset: grant `rd1` in cycle T and assert `rst` in cycle T+1.
  - Required: `rd1_rvalid` stays 0 in cycles T+2 and T+3.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Shares one two-port SRAM wrapper between two read clients and one write client.
// Port 0 is read/write, port 1 is read-only; read results return after the wrapper's 2-cycle latency.
module sram_port_arbiter #(
    parameter int unsigned SIZE_IN_WORDS = 1024,
    parameter int unsigned WORD_SIZE     = 32,
    parameter int unsigned ADDR_LEN      = $clog2(SIZE_IN_WORDS),
    parameter int unsigned STALL_MAX     = 3
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    rd0_valid,
    output logic                    rd0_ready,
    input  logic [ADDR_LEN-1:0]     rd0_addr,
    output logic                    rd0_rvalid,
    output logic [WORD_SIZE-1:0]    rd0_rdata,

    input  logic                    rd1_valid,
    output logic                    rd1_ready,
    input  logic [ADDR_LEN-1:0]     rd1_addr,
    output logic                    rd1_rvalid,
    output logic [WORD_SIZE-1:0]    rd1_rdata,

    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [ADDR_LEN-1:0]     wr_addr,
    input  logic [WORD_SIZE-1:0]    wr_data,
    input  logic [WORD_SIZE/8-1:0]  wr_mask,

    output logic                    nce0,
    output logic                    nwe0,
    output logic [ADDR_LEN-1:0]     addr0,
    output logic [WORD_SIZE-1:0]    wdata0,
    output logic [WORD_SIZE/8-1:0]  wmask0,
    input  logic [WORD_SIZE-1:0]    rdata0,

    output logic                    nce1,
    output logic [ADDR_LEN-1:0]     addr1,
    input  logic [WORD_SIZE-1:0]    rdata1
);

    localparam int unsigned MASK_W  = WORD_SIZE / 8;
    localparam int unsigned STALL_W = $clog2(STALL_MAX + 1);

    logic               rr, rr_nxt;
    logic [STALL_W-1:0] stall_cnt, stall_nxt;

    // Return pipeline, one lane per SRAM port: valid + client id
    logic s1_v0, s1_c0, s1_v1, s1_c1;
    logic s2_v0, s2_c0, s2_v1, s2_c1;

    logic stall_sat, wr_grant, hit0, hit1, elig0, elig1;
    logic p0r_v, p0r_cid, p1_v, p1_cid;

    // Grant decision and SRAM port drive
    always_comb begin
        rr_nxt    = rr;
        stall_nxt = stall_cnt;
        p0r_v     = 1'b0;
        p0r_cid   = 1'b0;
        p1_v      = 1'b0;
        p1_cid    = 1'b0;

        stall_sat = (stall_cnt == STALL_W'(STALL_MAX));
        wr_grant  = !rst && wr_valid && !stall_sat;
        hit0      = wr_grant && rd0_valid && (rd0_addr == wr_addr);
        hit1      = wr_grant && rd1_valid && (rd1_addr == wr_addr);
        elig0     = !rst && rd0_valid && !hit0;
        elig1     = !rst && rd1_valid && !hit1;

        if (elig0 && elig1) begin
            if (wr_grant) begin
                // Single slot: favoured client wins, pointer moves to the loser
                p1_v   = 1'b1;
                p1_cid = rr;
                rr_nxt = ~rr;
            end else begin
                p1_v    = 1'b1;
                p1_cid  = 1'b0;
                p0r_v   = 1'b1;
                p0r_cid = 1'b1;
            end
        end else if (elig0) begin
            p1_v   = 1'b1;
            p1_cid = 1'b0;
        end else if (elig1) begin
            p1_v   = 1'b1;
            p1_cid = 1'b1;
        end

        if (p1_v || p0r_v) begin
            stall_nxt = '0;
        end else if ((hit0 || hit1) && !stall_sat) begin
            stall_nxt = stall_cnt + STALL_W'(1);
        end

        wr_ready  = wr_grant;
        rd0_ready = (p1_v && !p1_cid) || (p0r_v && !p0r_cid);
        rd1_ready = (p1_v && p1_cid) || (p0r_v && p0r_cid);

        nce0   = !(wr_grant || p0r_v);
        nwe0   = !wr_grant;
        addr0  = wr_grant ? wr_addr : (p0r_cid ? rd1_addr : rd0_addr);
        wdata0 = wr_data;
        wmask0 = wr_grant ? wr_mask : MASK_W'(0);

        nce1  = !p1_v;
        addr1 = p1_cid ? rd1_addr : rd0_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr        <= 1'b0;
            stall_cnt <= '0;
            s1_v0     <= 1'b0;
            s1_c0     <= 1'b0;
            s1_v1     <= 1'b0;
            s1_c1     <= 1'b0;
            s2_v0     <= 1'b0;
            s2_c0     <= 1'b0;
            s2_v1     <= 1'b0;
            s2_c1     <= 1'b0;
        end else begin
            rr        <= rr_nxt;
            stall_cnt <= stall_nxt;
            s1_v0     <= p0r_v;
            s1_c0     <= p0r_cid;
            s1_v1     <= p1_v;
            s1_c1     <= p1_cid;
            s2_v0     <= s1_v0;
            s2_c0     <= s1_c0;
            s2_v1     <= s1_v1;
            s2_c1     <= s1_c1;
        end
    end

    // Route stage-2 results to the issuing client
    always_comb begin
        rd0_rvalid = !rst && ((s2_v0 && !s2_c0) || (s2_v1 && !s2_c1));
        rd1_rvalid = !rst && ((s2_v0 && s2_c0) || (s2_v1 && s2_c1));
        rd0_rdata  = (s2_v0 && !s2_c0) ? rdata0 : rdata1;
        rd1_rdata  = (s2_v0 && s2_c0) ? rdata0 : rdata1;
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a 2-cycle-latency two-port SRAM model.
module tb_sram_port_arbiter;

    localparam int unsigned WORDS = 1024;
    localparam int unsigned WS    = 32;
    localparam int unsigned AL    = 10;

    logic            clk = 1'b0;
    logic            rst;
    logic            rd0_valid, rd0_ready, rd0_rvalid;
    logic [AL-1:0]   rd0_addr;
    logic [WS-1:0]   rd0_rdata;
    logic            rd1_valid, rd1_ready, rd1_rvalid;
    logic [AL-1:0]   rd1_addr;
    logic [WS-1:0]   rd1_rdata;
    logic            wr_valid, wr_ready;
    logic [AL-1:0]   wr_addr;
    logic [WS-1:0]   wr_data;
    logic [3:0]      wr_mask;
    logic            nce0, nwe0, nce1;
    logic [AL-1:0]   addr0, addr1;
    logic [WS-1:0]   wdata0, rdata0, rdata1;
    logic [3:0]      wmask0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WS-1:0] mem [WORDS];
    logic [WS-1:0] p0_s1, p0_s2, p1_s1, p1_s2;

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .SIZE_IN_WORDS(WORDS), .WORD_SIZE(WS), .ADDR_LEN(AL), .STALL_MAX(3)
    ) dut (
        .clk(clk), .rst(rst),
        .rd0_valid(rd0_valid), .rd0_ready(rd0_ready), .rd0_addr(rd0_addr),
        .rd0_rvalid(rd0_rvalid), .rd0_rdata(rd0_rdata),
        .rd1_valid(rd1_valid), .rd1_ready(rd1_ready), .rd1_addr(rd1_addr),
        .rd1_rvalid(rd1_rvalid), .rd1_rdata(rd1_rdata),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_mask(wr_mask),
        .nce0(nce0), .nwe0(nwe0), .addr0(addr0), .wdata0(wdata0), .wmask0(wmask0),
        .rdata0(rdata0),
        .nce1(nce1), .addr1(addr1), .rdata1(rdata1)
    );

    // SRAM wrapper model: sample at the edge, data two cycles after grant
    always @(posedge clk) begin
        if (!nce0 && !nwe0) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask0[b]) mem[addr0][8*b +: 8] <= wdata0[8*b +: 8];
            end
        end
        p0_s1 <= mem[addr0];
        p0_s2 <= p0_s1;
        p1_s1 <= mem[addr1];
        p1_s2 <= p1_s1;
    end
    assign rdata0 = p0_s2;
    assign rdata1 = p1_s2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < int'(WORDS); i++) mem[i] = 32'h0;
        mem[1]   = 32'h1111_1111;
        mem[2]   = 32'h2222_2222;
        mem[3]   = 32'h3333_3333;
        mem[5]   = 32'hAAAA_0005;
        mem[9]   = 32'hDEAD_0009;
        mem[600] = 32'hBBBB_0258;

        rst = 1'b1;
        rd0_valid = 1'b1; rd0_addr = 10'd3;
        rd1_valid = 1'b0; rd1_addr = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = 4'h0;

        // Reset with rd0 requesting
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_rd0_ready", 32'(rd0_ready), 32'd0);
            check("rst_nce0", 32'(nce0), 32'd1);
            check("rst_nce1", 32'(nce1), 32'd1);
            check("rst_nwe0", 32'(nwe0), 32'd1);
            check("rst_rd0_rvalid", 32'(rd0_rvalid), 32'd0);
        end
        rst = 1'b0;
        #1;
        check("first_grant", 32'(rd0_ready), 32'd1);
        check("first_nce1", 32'(nce1), 32'd0);
        check("first_addr1", 32'(addr1), 32'd3);
        tick(); rd0_valid = 1'b0; #1;
        check("first_rvalid_t1", 32'(rd0_rvalid), 32'd0);
        tick();
        check("first_rvalid_t2", 32'(rd0_rvalid), 32'd1);
        check("first_rdata", rd0_rdata, 32'h3333_3333);
        tick();
        check("first_rvalid_t3", 32'(rd0_rvalid), 32'd0);

        // Dual read on both ports
        tick();
        rd0_valid = 1'b1; rd0_addr = 10'd5;
        rd1_valid = 1'b1; rd1_addr = 10'd600;
        #1;
        check("dual_rd0_ready", 32'(rd0_ready), 32'd1);
        check("dual_rd1_ready", 32'(rd1_ready), 32'd1);
        check("dual_nce0", 32'(nce0), 32'd0);
        check("dual_nwe0", 32'(nwe0), 32'd1);
        tick(); rd0_valid = 1'b0; rd1_valid = 1'b0; #1;
        tick();
        check("dual_rd0_rvalid", 32'(rd0_rvalid), 32'd1);
        check("dual_rd1_rvalid", 32'(rd1_rvalid), 32'd1);
        check("dual_rd0_rdata", rd0_rdata, 32'hAAAA_0005);
        check("dual_rd1_rdata", rd1_rdata, 32'hBBBB_0258);

        // Write plus two reads: round-robin on the single read slot
        wr_addr = 10'd7; wr_data = 32'h0707_0707; wr_mask = 4'hF;
        rd0_addr = 10'd1; rd1_addr = 10'd2;
        for (int i = 0; i < 6; i++) begin
            tick();
            wr_valid  = (i < 4);
            rd0_valid = (i < 4);
            rd1_valid = (i < 4);
            #1;
            if (i < 4) begin
                check("cont_wr_ready", 32'(wr_ready), 32'd1);
                check("cont_rd0_ready", 32'(rd0_ready), 32'((i % 2) == 0));
                check("cont_rd1_ready", 32'(rd1_ready), 32'((i % 2) == 1));
            end
            if (i >= 2) begin
                check("cont_rd0_rvalid", 32'(rd0_rvalid), 32'((i % 2) == 0));
                check("cont_rd1_rvalid", 32'(rd1_rvalid), 32'((i % 2) == 1));
                if ((i % 2) == 0) check("cont_rd0_rdata", rd0_rdata, 32'h1111_1111);
                else              check("cont_rd1_rdata", rd1_rdata, 32'h2222_2222);
            end
        end

        // Same-address collision: read waits one cycle, then sees the new data
        tick();
        wr_valid = 1'b1; wr_addr = 10'd9; wr_data = 32'h1234_5678; wr_mask = 4'hF;
        rd0_valid = 1'b1; rd0_addr = 10'd9;
        #1;
        check("coll_wr_ready", 32'(wr_ready), 32'd1);
        check("coll_rd0_stall", 32'(rd0_ready), 32'd0);
        tick(); wr_valid = 1'b0; #1;
        check("coll_rd0_grant", 32'(rd0_ready), 32'd1);
        tick(); rd0_valid = 1'b0; #1;
        check("coll_rvalid_t2", 32'(rd0_rvalid), 32'd0);
        tick();
        check("coll_rvalid_t3", 32'(rd0_rvalid), 32'd1);
        check("coll_rdata", rd0_rdata, 32'h1234_5678);

        // Starvation bound: write held off after three blocked cycles
        tick(); tick();
        wr_valid = 1'b1; wr_addr = 10'd9; wr_data = 32'h0000_9999; wr_mask = 4'hF;
        rd0_valid = 1'b1; rd0_addr = 10'd9;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("starve_wr_ready", 32'(wr_ready), 32'd1);
            check("starve_rd0_block", 32'(rd0_ready), 32'd0);
            tick();
        end
        check("starve_wr_held", 32'(wr_ready), 32'd0);
        check("starve_rd0_grant", 32'(rd0_ready), 32'd1);
        tick(); rd0_valid = 1'b0; #1;
        check("starve_wr_resume", 32'(wr_ready), 32'd1);
        tick(); wr_valid = 1'b0; #1;
        check("starve_rvalid", 32'(rd0_rvalid), 32'd1);
        check("starve_rdata", rd0_rdata, 32'h0000_9999);

        // Reset while a read is in flight
        tick(); tick();
        rd1_valid = 1'b1; rd1_addr = 10'd600;
        #1;
        check("mid_rd1_grant", 32'(rd1_ready), 32'd1);
        tick(); rd1_valid = 1'b0; rst = 1'b1; #1;
        tick(); rst = 1'b0; #1;
        check("mid_rvalid_t2", 32'(rd1_rvalid), 32'd0);
        tick();
        check("mid_rvalid_t3", 32'(rd1_rvalid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
